uart_rx_controller: RTL and testbench

UART_RX_CONTROLLER -- requirements
Module: uart_rx_controller

---
 rtl/uart_rx_controller.sv | 154 +++++++++++++++
 tb/tb_uart_rx_controller.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_controller.sv
// uart_rx_controller: accepts bytes from a UART Receive block over a four-phase
// receive/rx_done handshake and queues them in a show-ahead FIFO for a consumer.
// The receive flag is synchronized into ref_clk before any logic looks at it.
module uart_rx_controller #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     ref_clk,
  input  logic                     nreset,
  input  logic                     receive,
  input  logic [7:0]               data_in,
  output logic                     rx_done,
  input  logic                     cfg_parity_mode,
  output logic                     parity_mode,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_ACK     = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_receive_s;
  logic                   r_rx_done;
  logic                   r_parity_mode;
  logic                   r_overflow;
  logic [7:0]             r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [CW-1:0]          r_count;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_drop;
  logic                   w_load_parity;

  // Shift the asynchronous receive flag through the synchronizer chain.
  always_ff @(posedge ref_clk or negedge nreset) begin
    if (!nreset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], receive};
    end
  end

  assign w_receive_s = r_sync[SYNC_STAGES-1];

  // FIFO status derived from occupancy.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // A full FIFO still accepts a byte when the consumer pops in the same cycle;
  // a pop on an empty FIFO is ignored, so push-with-rd_en while empty is push only.
  assign w_push        = (r_state == S_CAPTURE) && (!w_full || rd_en);
  assign w_drop        = (r_state == S_CAPTURE) && w_full && !rd_en;
  assign w_pop         = rd_en && !w_empty;
  assign w_load_parity = (r_state == S_IDLE) && !w_receive_s;

  // Handshake state register.
  always_ff @(posedge ref_clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: one capture cycle per frame, then hold ACK until receive drops.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:    if (w_receive_s) w_next_state = S_CAPTURE;
      S_CAPTURE: w_next_state = S_ACK;
      S_ACK:     if (!w_receive_s) w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // rx_done is registered from the next state so it is high exactly while in ACK.
  always_ff @(posedge ref_clk or negedge nreset) begin
    if (!nreset) begin
      r_rx_done <= 1'b0;
    end else begin
      r_rx_done <= (w_next_state == S_ACK);
    end
  end

  // Parity mode only changes between frames so the Receive block never sees it move mid-frame.
  always_ff @(posedge ref_clk or negedge nreset) begin
    if (!nreset) begin
      r_parity_mode <= 1'b0;
    end else if (w_load_parity) begin
      r_parity_mode <= cfg_parity_mode;
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge ref_clk or negedge nreset) begin
    if (!nreset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (clr_overflow) begin
      r_overflow <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset because occupancy governs visibility.
  always_ff @(posedge ref_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge ref_clk or negedge nreset) begin
    if (!nreset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign rx_done     = r_rx_done;
  assign parity_mode = r_parity_mode;
  assign rd_data     = r_mem[r_rd_ptr];
  assign empty       = w_empty;
  assign full        = w_full;
  assign count       = r_count;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller: handshake latency, FIFO ordering,
// overflow behaviour, parity gating and reset handling.
module tb_uart_rx_controller;

  logic       ref_clk;
  logic       nreset;
  logic       receive;
  logic [7:0] data_in;
  logic       rx_done;
  logic       cfg_parity_mode;
  logic       parity_mode;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic       full;
  logic [2:0] count;
  logic       overflow;
  logic       clr_overflow;

  int n_vec  = 0;
  int n_miss = 0;

  uart_rx_controller #(.DEPTH(4), .SYNC_STAGES(2)) dut (
    .ref_clk         (ref_clk),
    .nreset          (nreset),
    .receive         (receive),
    .data_in         (data_in),
    .rx_done         (rx_done),
    .cfg_parity_mode (cfg_parity_mode),
    .parity_mode     (parity_mode),
    .rd_en           (rd_en),
    .rd_data         (rd_data),
    .empty           (empty),
    .full            (full),
    .count           (count),
    .overflow        (overflow),
    .clr_overflow    (clr_overflow)
  );

  initial ref_clk = 1'b0;
  always #5 ref_clk = ~ref_clk;

  // Compare one observed value with its expected value.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One rising edge, then return on the following falling edge.
  task automatic tick();
    @(posedge ref_clk);
    @(negedge ref_clk);
  endtask

  // Wait (bounded) for rx_done to reach a level.
  task automatic wait_rx(input logic lvl, input string tag);
    for (int i = 0; i < 12; i++) begin
      if (rx_done === lvl) break;
      tick();
    end
    check_val(tag, rx_done, lvl);
  endtask

  // Full frame with fixed-latency capture; pop/clr are applied in the CAPTURE cycle.
  task automatic send_frame(input logic [7:0] d, input logic pop, input logic clr);
    receive = 1'b1;
    data_in = d;
    tick();             // edge k
    tick();             // edge k+1
    tick();             // edge k+2: now in CAPTURE
    rd_en        = pop;
    clr_overflow = clr;
    tick();             // edge k+3: push, rx_done rises
    rd_en        = 1'b0;
    clr_overflow = 1'b0;
    check_val("frame_rx_done_rise", rx_done, 1'b1);
    receive = 1'b0;
    wait_rx(1'b0, "frame_rx_done_fall");
    tick();
  endtask

  // Pop the head after checking it.
  task automatic pop_expect(input logic [7:0] d, input string tag);
    check_val(tag, rd_data, d);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    nreset          = 1'b0;
    receive         = 1'b0;
    data_in         = 8'h00;
    cfg_parity_mode = 1'b0;
    rd_en           = 1'b0;
    clr_overflow    = 1'b0;

    // Reset state
    #2;
    check_val("rst_rx_done",  rx_done,     1'b0);
    check_val("rst_parity",   parity_mode, 1'b0);
    check_val("rst_count",    count,       3'd0);
    check_val("rst_empty",    empty,       1'b1);
    check_val("rst_full",     full,        1'b0);
    check_val("rst_overflow", overflow,    1'b0);
    @(negedge ref_clk);
    @(negedge ref_clk);
    nreset = 1'b1;
    tick();

    // Single frame 0xCD with exact latency
    receive = 1'b1;
    data_in = 8'hCD;
    tick();  // k
    check_val("sf_count_k", count, 3'd0);
    tick();  // k+1
    tick();  // k+2
    check_val("sf_count_k2",  count,   3'd0);
    check_val("sf_rxdone_k2", rx_done, 1'b0);
    tick();  // k+3
    check_val("sf_count_k3",  count,   3'd1);
    check_val("sf_rddata_k3", rd_data, 8'hCD);
    check_val("sf_rxdone_k3", rx_done, 1'b1);
    check_val("sf_empty_k3",  empty,   1'b0);
    receive = 1'b0;
    tick();  // j
    check_val("sf_rxdone_j",  rx_done, 1'b1);
    tick();  // j+1
    check_val("sf_rxdone_j1", rx_done, 1'b1);
    tick();  // j+2
    tick();  // j+3
    check_val("sf_rxdone_j3", rx_done,     1'b0);
    check_val("sf_parity",    parity_mode, 1'b0);
    pop_expect(8'hCD, "sf_pop");
    check_val("sf_empty_after", empty, 1'b1);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    check_val("pop_empty_count", count, 3'd0);
    check_val("pop_empty_empty", empty, 1'b1);

    // Fill and overflow
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b0, 1'b0);
    check_val("fill_full",  full,     1'b1);
    check_val("fill_count", count,    3'd4);
    check_val("fill_ovf0",  overflow, 1'b0);
    send_frame(8'h05, 1'b0, 1'b0);
    check_val("ovf_set",   overflow, 1'b1);
    check_val("ovf_count", count,    3'd4);
    for (int i = 1; i <= 4; i++) pop_expect(8'(i), "ovf_pop");
    check_val("ovf_empty", empty, 1'b1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check_val("ovf_clr", overflow, 1'b0);

    // Full with a same-cycle pop
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b0, 1'b0);
    send_frame(8'h47, 1'b1, 1'b0);
    check_val("fp_count", count,    3'd4);
    check_val("fp_ovf",   overflow, 1'b0);
    pop_expect(8'h12, "fp_pop0");
    pop_expect(8'h13, "fp_pop1");
    pop_expect(8'h14, "fp_pop2");
    pop_expect(8'h47, "fp_pop3");
    check_val("fp_empty", empty, 1'b1);

    // Parity gating: cfg changes while in ACK
    receive = 1'b1;
    data_in = 8'h5A;
    tick(); tick(); tick(); tick();
    check_val("par_in_ack", rx_done, 1'b1);
    cfg_parity_mode = 1'b1;
    tick();
    check_val("par_hold_ack", parity_mode, 1'b0);
    receive = 1'b0;
    tick();  // j
    tick();  // j+1
    tick();  // j+2: first IDLE cycle begins
    check_val("par_hold_idle_entry", parity_mode, 1'b0);
    tick();  // j+3
    check_val("par_loaded", parity_mode, 1'b1);
    pop_expect(8'h5A, "par_pop");

    // Overflow clear race
    for (int i = 0; i < 4; i++) send_frame(8'h21 + 8'(i), 1'b0, 1'b0);
    send_frame(8'h25, 1'b0, 1'b1);
    check_val("race_ovf_set", overflow, 1'b1);
    clr_overflow = 1'b1;
    tick();
    clr_overflow = 1'b0;
    check_val("race_ovf_clr", overflow, 1'b0);
    pop_expect(8'h21, "race_pop0");
    pop_expect(8'h22, "race_pop1");
    pop_expect(8'h23, "race_pop2");

    // Reset mid-ACK with count=2
    receive = 1'b1;
    data_in = 8'h99;
    tick(); tick(); tick(); tick();
    check_val("mid_rx_done", rx_done, 1'b1);
    check_val("mid_count",   count,   3'd2);
    #2;
    nreset = 1'b0;
    #1;
    check_val("mid_rst_rx_done",  rx_done,     1'b0);
    check_val("mid_rst_parity",   parity_mode, 1'b0);
    check_val("mid_rst_count",    count,       3'd0);
    check_val("mid_rst_empty",    empty,       1'b1);
    check_val("mid_rst_full",     full,        1'b0);
    check_val("mid_rst_overflow", overflow,    1'b0);
    receive = 1'b0;
    @(negedge ref_clk);
    nreset = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    check_val("post_rst_count",   count,   3'd0);
    check_val("post_rst_rx_done", rx_done, 1'b0);

    // receive already high when reset releases
    #2;
    nreset  = 1'b0;
    receive = 1'b1;
    data_in = 8'h3C;
    @(negedge ref_clk);
    nreset = 1'b1;
    wait_rx(1'b1, "rel_rx_done_rise");
    check_val("rel_count",  count,   3'd1);
    check_val("rel_rddata", rd_data, 8'h3C);
    receive = 1'b0;
    wait_rx(1'b0, "rel_rx_done_fall");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
